key_loader: RTL
===============

# key_loader

Sequential key-delivery stage sitting directly upstream of a logic-locked netlist. Receives the unlock key over a one-bit serial stream after a start strobe, checks it, and commits it write-once to a parallel key bus driving the locked circuit's `keyIn0_0..keyIn0_{KEY_WIDTH-1}` inputs. Until a valid key is committed, the bus is held at all-zeros, so the locked circuit sees a deterministic (wrong) key.

## Interface
- `KEY_WIDTH`, 4, number of key bits; `key_out[i]` drives `keyIn0_i`; legal range 1..256
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `load_start`  input  1  one-cycle strobe: begin (or restart) a key load
- `ser_valid`  input  1  `ser_in` carries a bit this cycle
- `ser_in`  input  1  serial key bit, LSB (`keyIn0_0`) first
- `key_out`  output  KEY_WIDTH  committed key bus to locked circuit
- `key_ready`  output  1  key committed (sticky until rst)
- `busy`  output  1  load in progress (SHIFT or CHECK)
- `err`  output  1  last load failed check (sticky until next accepted load_start or rst)

## Operation
- States: IDLE, SHIFT, CHECK, DONE. Reset state IDLE.
- IDLE:
  - `load_start` → SHIFT; clear shadow register, bit counter, and `err`.
  - `ser_valid` is ignored.
- SHIFT:
  - Each cycle with `ser_valid=1`, the current bit is accepted. Key bits go to `shadow[cnt]`. `cnt` increments.
  - Accepted bits per load: KEY_WIDTH, plus one parity bit when parity is enabled (see Configuration).
  - Accepting the final bit → CHECK.
  - `load_start` in SHIFT restarts the load: shadow and cnt cleared, stay in SHIFT. A bit offered in the same cycle is dropped.
- CHECK (exactly one cycle):
  - Check passes → `key_out <= shadow`, `key_ready <= 1`, → DONE.
  - Check fails → `key_out` unchanged (zeros), `err <= 1`, → IDLE.
- DONE:
  - Terminal until `rst`.
  - `load_start` and `ser_valid` are ignored. Write-once: the key cannot be overwritten without reset.
- `busy` = state is SHIFT or CHECK.
- `cnt` width: `$clog2(KEY_WIDTH+2)`. No wrap: the counter never exceeds KEY_WIDTH.
- `rst` in any state, including mid-SHIFT or CHECK:
  - State → IDLE.
  - `key_out`, `key_ready`, `busy`, `err`, shadow, and cnt all → 0.

## Timing
- Reset values: `key_out=0`, `key_ready=0`, `busy=0`, `err=0`.
- `load_start` sampled at edge E → `busy=1` after E. The earliest bit accepted is at edge E+1.
- Final bit accepted at edge N → CHECK during cycle N..N+1.
- `key_out` and `key_ready` (or `err`) update at edge N+1. `busy` drops at N+1.
- Minimum load: 1 + (KEY_WIDTH [+1]) + 1 cycles from strobe to `key_ready`.
- `ser_valid` gaps are permitted; SHIFT waits indefinitely (no timeout).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `KEY_LOADER_PARITY_EN`.
- Defined:
  - After KEY_WIDTH key bits, one extra parity bit is accepted.
  - Check passes iff XOR of the key bits equals the parity bit (even parity over key+parity).
- Undefined:
  - Exactly KEY_WIDTH bits are accepted; the check always passes.
  - `err` is tied to 0.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0 and state IDLE. Then `ser_valid` pulses without `load_start` → `key_out` stays 4'b0000.
- Good load (parity en, KEY_WIDTH=4): `load_start`, then bits 1,0,1,1, parity 1, back-to-back → `key_out=4'b1101`, `key_ready=1` exactly one edge after the parity bit; `busy` high for 6 cycles.
- Bad parity: bits 1,0,1,1, parity 0 → `err=1`, `key_ready=0`, `key_out=0`. A following good load clears `err` on `load_start` and commits 4'b1101.
- Restart and gaps: `load_start`, bits 1,1, then `load_start` with `ser_valid=1` (bit dropped). Then bits 0,1,0,0, parity 1, with 3-cycle idle gaps → `key_out=4'b0010`.
- Write-once: after a commit of 4'b1101, send `load_start` + 0,0,0,0,0 → `key_out` stays 4'b1101 and `busy` stays 0.
- Mid-load reset: `rst` after 2 key bits → outputs 0 and IDLE. A fresh load of 0,1,1,0, parity 0 → `key_out=4'b0110`. With the macro undefined, 0,1,1,0 alone commits 4'b0110.

Source files
------------

// File: rtl/key_loader.sv
// ============================================================================
// key_loader : serial-in, write-once key delivery stage for a locked netlist.
// Optional parity check enabled by `define KEY_LOADER_PARITY_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module key_loader #(
  parameter int KEY_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 ser_valid,
  input  logic                 ser_in,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(KEY_WIDTH + 2);

`ifdef KEY_LOADER_PARITY_EN
  localparam int C_NBITS = KEY_WIDTH + 1;
`else
  localparam int C_NBITS = KEY_WIDTH;
`endif

  localparam logic [CW-1:0] C_LAST = CW'(C_NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [KEY_WIDTH-1:0] r_shadow;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_ready;
  logic                 w_pass;

`ifdef KEY_LOADER_PARITY_EN
  logic r_par;
  logic r_err;
  // Even parity across key bits plus the trailing parity bit.
  assign w_pass = ((^r_shadow) == r_par);
`else
  assign w_pass = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_key    <= '0;
      r_ready  <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      r_par    <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state  <= S_SHIFT;
            r_cnt    <= '0;
            r_shadow <= '0;
`ifdef KEY_LOADER_PARITY_EN
            r_par    <= 1'b0;
            r_err    <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (load_start) begin
            r_cnt    <= '0;
            r_shadow <= '0;
`ifdef KEY_LOADER_PARITY_EN
            r_par    <= 1'b0;
`endif
          end else if (ser_valid) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
              if (r_cnt == CW'(i)) r_shadow[i] <= ser_in;
            end
`ifdef KEY_LOADER_PARITY_EN
            if (r_cnt == CW'(KEY_WIDTH)) r_par <= ser_in;
`endif
            // Counter holds on the final bit so it never passes KEY_WIDTH.
            if (r_cnt == C_LAST) r_state <= S_CHECK;
            else                 r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_pass) begin
            r_key   <= r_shadow;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
`ifdef KEY_LOADER_PARITY_EN
            r_err   <= 1'b1;
`endif
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  assign key_out   = r_key;
  assign key_ready = r_ready;
  assign busy      = (r_state == S_SHIFT) || (r_state == S_CHECK);
`ifdef KEY_LOADER_PARITY_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire
